// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin sharing of one hardware stack between
// two requesters, with occupancy tracking and error responses.
module stack_arbiter #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_valid,
    input  logic                     a_op,
    input  logic [WIDTH-1:0]         a_wdata,
    input  logic                     b_valid,
    input  logic                     b_op,
    input  logic [WIDTH-1:0]         b_wdata,
    output logic                     a_ready,
    output logic                     b_ready,
    output logic                     a_resp,
    output logic                     b_resp,
    output logic                     a_err,
    output logic                     b_err,
    output logic [WIDTH-1:0]         resp_data,
    output logic                     stk_push,
    output logic                     stk_pop,
    output logic [WIDTH-1:0]         stk_wdata,
    input  logic [WIDTH-1:0]         stk_rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] MAXC = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        POP_ISSUE,
        POP_CAPTURE
    } state_t;

    state_t           r_state;
    logic             r_ptr;
    logic             r_pop_b;
    logic [CW-1:0]    r_count;
    logic             r_push;
    logic             r_pop;
    logic [WIDTH-1:0] r_wdata;
    logic             r_a_resp;
    logic             r_b_resp;
    logic             r_a_err;
    logic             r_b_err;
    logic [WIDTH-1:0] r_rdata;

    logic             w_idle;
    logic             w_a_gnt;
    logic             w_b_gnt;
    logic             w_acc;
    logic             w_op;
    logic [WIDTH-1:0] w_wdata;
    logic             w_full;
    logic             w_empty;

    // Grant selection: single requester wins outright, ties go to pointer
    always_comb begin
        w_idle  = (r_state == IDLE);
        w_a_gnt = w_idle && a_valid && (!b_valid || !r_ptr);
        w_b_gnt = w_idle && b_valid && (!a_valid || r_ptr);
        w_acc   = w_a_gnt || w_b_gnt;
        w_op    = w_b_gnt ? b_op : a_op;
        w_wdata = w_b_gnt ? b_wdata : a_wdata;
        w_full  = (r_count == MAXC);
        w_empty = (r_count == '0);
    end

    assign a_ready   = w_a_gnt;
    assign b_ready   = w_b_gnt;
    assign a_resp    = r_a_resp;
    assign b_resp    = r_b_resp;
    assign a_err     = r_a_err;
    assign b_err     = r_b_err;
    assign resp_data = r_rdata;
    assign stk_wdata = r_wdata;
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;

    // Strobes are masked by rst so the stack never moves while resetting
    assign stk_push  = r_push & ~rst;
    assign stk_pop   = r_pop & ~rst;

    // Arbitration FSM, occupancy counter and registered responses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ptr    <= 1'b0;
            r_pop_b  <= 1'b0;
            r_count  <= '0;
            r_push   <= 1'b0;
            r_pop    <= 1'b0;
            r_wdata  <= '0;
            r_a_resp <= 1'b0;
            r_b_resp <= 1'b0;
            r_a_err  <= 1'b0;
            r_b_err  <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_push   <= 1'b0;
            r_pop    <= 1'b0;
            r_wdata  <= '0;
            r_a_resp <= 1'b0;
            r_b_resp <= 1'b0;
            r_a_err  <= 1'b0;
            r_b_err  <= 1'b0;
            r_rdata  <= '0;
            unique case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        r_ptr <= w_a_gnt;
                        if (!w_op) begin
                            r_a_resp <= w_a_gnt;
                            r_b_resp <= w_b_gnt;
                            if (w_full) begin
                                r_a_err <= w_a_gnt;
                                r_b_err <= w_b_gnt;
                            end else begin
                                r_push  <= 1'b1;
                                r_wdata <= w_wdata;
                                r_count <= r_count + 1'b1;
                            end
                        end else if (w_empty) begin
                            r_a_resp <= w_a_gnt;
                            r_b_resp <= w_b_gnt;
                            r_a_err  <= w_a_gnt;
                            r_b_err  <= w_b_gnt;
                        end else begin
                            r_pop   <= 1'b1;
                            r_count <= r_count - 1'b1;
                            r_pop_b <= w_b_gnt;
                            r_state <= POP_ISSUE;
                        end
                    end
                end
                POP_ISSUE: begin
                    r_state <= POP_CAPTURE;
                end
                POP_CAPTURE: begin
                    r_rdata  <= stk_rdata;
                    r_a_resp <= !r_pop_b;
                    r_b_resp <= r_pop_b;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

Shares one 256-entry x 8-bit hardware stack between two requesters, A and B, using round-robin arbitration. Each requester issues push or pop transactions over a valid/ready handshake and receives a one-shot response. The block tracks stack occupancy, so it never drives a push into a full stack or a pop from an empty one; such requests complete with an error response instead. It sits between the stack primitive and its clients, for example a call-stack unit and a data-stack unit.

## Interface
- DEPTH, 256: stack capacity in entries.
- WIDTH, 8: data width.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- a_valid, b_valid  in  1  request present.
- a_op, b_op  in  1  0 = push, 1 = pop.
- a_wdata, b_wdata  in  WIDTH  push data.
- a_ready, b_ready  out  1  request accepted this cycle (combinational).
- a_resp, b_resp  out  1  one-cycle response strobe.
- a_err, b_err  out  1  qualifies resp: push while full, or pop while empty.
- resp_data  out  WIDTH  pop data, shared; valid with a_resp/b_resp on a non-error pop, otherwise 0.
- stk_push  out  1  stack push strobe, one cycle.
- stk_pop  out  1  stack pop strobe, one cycle.
- stk_wdata  out  WIDTH  data accompanying stk_push.
- stk_rdata  in  WIDTH  stack read data; valid the cycle after stk_pop.
- count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full, empty  out  1  count==DEPTH / count==0.

## Operation
- Reset values:
  - All strobes, resp, err, resp_data and stk_wdata are 0.
  - count = 0, empty = 1, full = 0.
  - State = IDLE, priority pointer = A.
- FSM states: IDLE, POP_ISSUE, POP_CAPTURE.
- Arbitration (IDLE only):
  - If one requester is valid, it is granted.
  - If both are valid, the requester named by the pointer is granted.
  - After any grant, including an error grant, the pointer moves to the other requester.
  - Exactly one ready is high for the granted requester; in non-IDLE states both readies are 0.
- Accepted push, not full:
  - Next cycle: stk_push=1, stk_wdata=wdata, count+1, resp=1 with err=0.
  - State stays IDLE, so back-to-back pushes are accepted every cycle.
- Accepted push, full: no stk_push, count unchanged; next cycle resp=1, err=1.
- Accepted pop, not empty:
  - Go to POP_ISSUE: stk_pop=1, count-1.
  - Then POP_CAPTURE: resp_data=stk_rdata is registered.
  - Then IDLE: resp=1, err=0 during the first IDLE cycle.
  - New requests may be granted in that same IDLE cycle.
- Accepted pop, empty: no stk_pop; next cycle resp=1, err=1, resp_data=0; state stays IDLE.
- Count arithmetic:
  - count is unsigned with no wrap.
  - Push is gated at DEPTH; pop is gated at 0.
- Reset mid-operation:
  - A reset in any state returns to IDLE and drops any pending response.
  - No stk_push or stk_pop is asserted in the cycle after the reset cycle.
  - The stack contents are not cleared by this block; count=0 defines them as invalid.

## Timing
- Handshake: a transfer occurs on a posedge where valid&ready=1.
- Requesters must hold valid, op and wdata stable until ready.
- ready depends combinationally on valid, pointer and state only, never on the other requester's ready.
- Push latency: accept edge N, then stk_push and resp during cycle N+1.
- Pop latency:
  - stk_pop during cycle N+1.
  - Data captured at the end of N+2.
  - resp during N+3.
  - Throughput: at most 1 pop per 3 cycles.
- Error latency: resp during N+1 for both ops.
- stk_push and stk_pop are never high together, and never high while rst=1.
- At most one of a_resp and b_resp is high per cycle.

## Test plan
- Reset, then A pushes 0x11, 0x22, 0x33 back-to-back:
  - stk_push is high for 3 consecutive cycles with wdata 11, 22, 33.
  - count ends at 3.
  - Three a_resp pulses, all with err=0.
- A and B both valid with push, held for 4 cycles:
  - Grants alternate A, B, A, B.
  - With both valid, the first grant after reset goes to A.
- After pushing 0x5A, B pops:
  - stk_pop is asserted once.
  - b_resp comes 3 cycles after acceptance with resp_data=0x5A.
  - count returns to 0; ready is low for both requesters during POP_ISSUE and POP_CAPTURE.
- Pop when count=0: a_resp with a_err=1 and resp_data=0 the next cycle; no stk_pop is asserted.
- Fill to DEPTH (full=1), then push 0xFF: a_err=1, no stk_push, count stays 256.
- Assert rst during POP_CAPTURE:
  - No resp follows.
  - count=0, state is IDLE.
  - A new push is accepted 1 cycle after rst falls.
